// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker
//
// Receive-frame checker sitting between the UART receiver shift register and
// the host read interface. Each assembled frame is checked for parity
// (none / odd / even) and stop bits, then held in a one-entry buffer with a
// valid/ready handshake. Frames arriving while the buffer is full and not
// being read are dropped and reported as overruns. Error status is kept in
// sticky bits. Optional saturating error counters can be compiled in.
//
// Compile-time option:
//   RX_ERR_COUNTERS_EN  defined   -> three saturating error counters are built
//                       undefined -> counter ports are tied to zero
//
// Ports:
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   frame_in         in   {stop bits, [parity], data}, data LSB first received
//   frame_valid      in   single-cycle strobe, frame_in is complete
//   data_out         out  buffered data word
//   data_valid       out  buffer holds an unread word
//   data_ready       in   consumer takes data_out this cycle
//   parity_error     out  parity error of the buffered word
//   framing_error    out  framing error of the buffered word
//   overrun_error    out  one-cycle pulse, a frame was dropped
//   status_clear     in   clears sticky status and counters
//   sticky_status    out  {overrun, framing, parity}, set-only until cleared
//   parity_err_cnt   out  captured parity errors (saturating)
//   framing_err_cnt  out  captured framing errors (saturating)
//   overrun_cnt      out  dropped frames (saturating)
//
// Buffer FSM:
//   state | meaning
//   EMPTY | no unread word, data_valid = 0
//   FULL  | one unread word held, data_valid = 1

module uart_rx_frame_checker #(
    parameter int DATA_BITS   = 7,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int CNT_WIDTH   = 8,
    localparam int PAR_W      = (PARITY_MODE != 0) ? 1 : 0,
    localparam int FRAME_W    = DATA_BITS + PAR_W + STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FRAME_W-1:0]   frame_in,
    input  logic                 frame_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error,
    input  logic                 status_clear,
    output logic [2:0]           sticky_status,
    output logic [CNT_WIDTH-1:0] parity_err_cnt,
    output logic [CNT_WIDTH-1:0] framing_err_cnt,
    output logic [CNT_WIDTH-1:0] overrun_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t state_q, state_d;

    logic [DATA_BITS-1:0] frame_data;
    logic [STOP_BITS-1:0] frame_stop;
    logic                 frame_par_err;
    logic                 frame_frm_err;

    logic                 capture;
    logic                 overrun;

    logic [DATA_BITS-1:0] data_q;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 overrun_q;
    logic [2:0]           sticky_q;
    logic [2:0]           sticky_d;

    // ------------------------------------------------------------------
    // Frame decode and checks
    // ------------------------------------------------------------------
    assign frame_data = frame_in[DATA_BITS-1:0];
    assign frame_stop = frame_in[FRAME_W-1 -: STOP_BITS];

    // With parity disabled, frame_in[DATA_BITS] is a stop bit; it is only
    // looked at in the parity branches, which are then unreachable.
    always_comb begin
        frame_par_err = 1'b0;
        if (PARITY_MODE == 1) begin
            frame_par_err = ~((^frame_data) ^ frame_in[DATA_BITS]);
        end else if (PARITY_MODE == 2) begin
            frame_par_err = (^frame_data) ^ frame_in[DATA_BITS];
        end
    end

    assign frame_frm_err = ~(&frame_stop);

    // ------------------------------------------------------------------
    // Buffer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame arriving in the same cycle the held word is read replaces it
    // and keeps the buffer FULL; only an unread FULL buffer drops frames.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        overrun = 1'b0;
        case (state_q)
            EMPTY: begin
                if (frame_valid) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (frame_valid && data_ready) begin
                    capture = 1'b1;
                end else if (frame_valid) begin
                    overrun = 1'b1;
                end else if (data_ready) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data buffer and per-word flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun;
            if (capture) begin
                data_q    <= frame_data;
                par_err_q <= frame_par_err;
                frm_err_q <= frame_frm_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status: clear first, then OR in new events so a set wins
    // ------------------------------------------------------------------
    always_comb begin
        sticky_d = status_clear ? 3'b000 : sticky_q;
        sticky_d = sticky_d | {overrun,
                               capture & frame_frm_err,
                               capture & frame_par_err};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional saturating error counters
    // ------------------------------------------------------------------
`ifdef RX_ERR_COUNTERS_EN
    logic [CNT_WIDTH-1:0] par_cnt_q;
    logic [CNT_WIDTH-1:0] frm_cnt_q;
    logic [CNT_WIDTH-1:0] ovr_cnt_q;

    // Clear is applied before the increment, so clear + increment gives 1.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 clr,
        input logic                 inc
    );
        logic [CNT_WIDTH-1:0] base;
        base = clr ? '0 : cur;
        if (inc && (base != {CNT_WIDTH{1'b1}})) begin
            base = base + CNT_WIDTH'(1);
        end
        return base;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
            ovr_cnt_q <= '0;
        end else begin
            par_cnt_q <= cnt_next(par_cnt_q, status_clear, capture & frame_par_err);
            frm_cnt_q <= cnt_next(frm_cnt_q, status_clear, capture & frame_frm_err);
            ovr_cnt_q <= cnt_next(ovr_cnt_q, status_clear, overrun);
        end
    end

    assign parity_err_cnt  = par_cnt_q;
    assign framing_err_cnt = frm_cnt_q;
    assign overrun_cnt     = ovr_cnt_q;
`else
    assign parity_err_cnt  = '0;
    assign framing_err_cnt = '0;
    assign overrun_cnt     = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out      = data_q;
    assign data_valid    = (state_q == FULL);
    assign parity_error  = par_err_q;
    assign framing_error = frm_err_q;
    assign overrun_error = overrun_q;
    assign sticky_status = sticky_q;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
module tb_uart_rx_frame_checker;

`ifdef RX_ERR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int n_tests;
    int n_failed;

    // Default configuration: 7 data bits, odd parity, 1 stop bit
    logic [8:0] a_frame;
    logic       a_fv, a_rdy, a_clr;
    logic [6:0] a_data;
    logic       a_dv, a_perr, a_ferr, a_ovr;
    logic [2:0] a_sticky;
    logic [7:0] a_pcnt, a_fcnt, a_ocnt;

    // Narrow counters for saturation
    logic [8:0] s_frame;
    logic       s_fv, s_rdy, s_clr;
    logic [6:0] s_data;
    logic       s_dv, s_perr, s_ferr, s_ovr;
    logic [2:0] s_sticky;
    logic [1:0] s_pcnt, s_fcnt, s_ocnt;

    // Even parity, 2 stop bits
    logic [9:0] e_frame;
    logic       e_fv, e_rdy, e_clr;
    logic [6:0] e_data;
    logic       e_dv, e_perr, e_ferr, e_ovr;
    logic [2:0] e_sticky;
    logic [7:0] e_pcnt, e_fcnt, e_ocnt;

    uart_rx_frame_checker dut (
        .clk(clk), .rst_n(rst_n),
        .frame_in(a_frame), .frame_valid(a_fv),
        .data_out(a_data), .data_valid(a_dv), .data_ready(a_rdy),
        .parity_error(a_perr), .framing_error(a_ferr), .overrun_error(a_ovr),
        .status_clear(a_clr), .sticky_status(a_sticky),
        .parity_err_cnt(a_pcnt), .framing_err_cnt(a_fcnt), .overrun_cnt(a_ocnt)
    );

    uart_rx_frame_checker #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .frame_in(s_frame), .frame_valid(s_fv),
        .data_out(s_data), .data_valid(s_dv), .data_ready(s_rdy),
        .parity_error(s_perr), .framing_error(s_ferr), .overrun_error(s_ovr),
        .status_clear(s_clr), .sticky_status(s_sticky),
        .parity_err_cnt(s_pcnt), .framing_err_cnt(s_fcnt), .overrun_cnt(s_ocnt)
    );

    uart_rx_frame_checker #(.PARITY_MODE(2), .STOP_BITS(2)) dut_even (
        .clk(clk), .rst_n(rst_n),
        .frame_in(e_frame), .frame_valid(e_fv),
        .data_out(e_data), .data_valid(e_dv), .data_ready(e_rdy),
        .parity_error(e_perr), .framing_error(e_ferr), .overrun_error(e_ovr),
        .status_clear(e_clr), .sticky_status(e_sticky),
        .parity_err_cnt(e_pcnt), .framing_err_cnt(e_fcnt), .overrun_cnt(e_ocnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    // Advance one clock; inputs and samples both sit 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [8:0] f, input logic rdy, input logic clr);
        a_frame = f; a_fv = 1'b1; a_rdy = rdy; a_clr = clr;
        tick();
        a_fv = 1'b0; a_rdy = 1'b0; a_clr = 1'b0;
    endtask

    task automatic e_send(input logic [9:0] f, input logic rdy);
        e_frame = f; e_fv = 1'b1; e_rdy = rdy;
        tick();
        e_fv = 1'b0; e_rdy = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_failed = 0;
        a_frame = '0; a_fv = 0; a_rdy = 0; a_clr = 0;
        s_frame = '0; s_fv = 0; s_rdy = 0; s_clr = 0;
        e_frame = '0; e_fv = 0; e_rdy = 0; e_clr = 0;
        rst_n = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_dv",     a_dv, 0);
        check("rst_data",   a_data, 0);
        check("rst_perr",   a_perr, 0);
        check("rst_ferr",   a_ferr, 0);
        check("rst_ovr",    a_ovr, 0);
        check("rst_sticky", a_sticky, 0);
        check("rst_pcnt",   a_pcnt, 0);
        rst_n = 1'b1;
        tick();

        // Good frame, one-cycle latency
        a_frame = 9'h1C1; a_fv = 1'b1;
        @(posedge clk); #1;
        a_fv = 1'b0;
        check("good_dv",     a_dv, 1);
        check("good_data",   a_data, 7'h41);
        check("good_perr",   a_perr, 0);
        check("good_ferr",   a_ferr, 0);
        check("good_sticky", a_sticky, 3'b000);

        // Overrun: frame dropped while FULL and not read
        a_send(9'h1C2, 1'b0, 1'b0);
        check("ovr_data",   a_data, 7'h41);
        check("ovr_dv",     a_dv, 1);
        check("ovr_pulse",  a_ovr, 1);
        check("ovr_sticky", a_sticky, 3'b100);
        check("ovr_cnt",    a_ocnt, ecnt(1));
        tick();
        check("ovr_pulse_end", a_ovr, 0);

        // Consume, then clear status
        a_rdy = 1'b1; tick(); a_rdy = 1'b0;
        check("consume_dv", a_dv, 0);
        a_rdy = 1'b1; tick(); a_rdy = 1'b0;
        check("empty_ready_dv", a_dv, 0);
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        check("clr_sticky", a_sticky, 3'b000);
        check("clr_ocnt",   a_ocnt, 0);

        // Parity error
        a_send(9'h141, 1'b0, 1'b0);
        check("perr_flag",   a_perr, 1);
        check("perr_ferr",   a_ferr, 0);
        check("perr_sticky", a_sticky, 3'b001);
        check("perr_cnt",    a_pcnt, ecnt(1));

        // Framing error captured in the same cycle the held word is read
        a_send(9'h0C1, 1'b1, 1'b0);
        check("ferr_flag",   a_ferr, 1);
        check("ferr_perr",   a_perr, 0);
        check("ferr_dv",     a_dv, 1);
        check("ferr_noovr",  a_ovr, 0);
        check("ferr_sticky", a_sticky, 3'b011);
        check("ferr_fcnt",   a_fcnt, ecnt(1));
        check("ferr_pcnt",   a_pcnt, ecnt(1));

        // Simultaneous read + capture, frame with both errors
        a_send(9'h055, 1'b1, 1'b0);
        check("sim_data",  a_data, 7'h55);
        check("sim_dv",    a_dv, 1);
        check("sim_noovr", a_ovr, 0);
        check("sim_ferr",  a_ferr, 1);
        check("sim_perr",  a_perr, 1);
        check("sim_fcnt",  a_fcnt, ecnt(2));

        // Clear coinciding with a parity-error capture: set wins
        a_send(9'h141, 1'b1, 1'b1);
        check("clrset_sticky", a_sticky, 3'b001);
        check("clrset_pcnt",   a_pcnt, ecnt(1));
        check("clrset_fcnt",   a_fcnt, 0);

        // Back-to-back frames with data_ready held
        a_send(9'h1C1, 1'b1, 1'b0);
        check("tp0_data", a_data, 7'h41);
        a_send(9'h1C2, 1'b1, 1'b0);
        check("tp1_data", a_data, 7'h42);
        check("tp1_ovr",  a_ovr, 0);
        check("tp1_perr", a_perr, 0);

        // Counter saturation on narrow counters
        for (int i = 0; i < 5; i++) begin
            s_frame = 9'h141; s_fv = 1'b1; s_rdy = 1'b1;
            tick();
        end
        s_fv = 1'b0; s_rdy = 1'b0;
        check("sat_pcnt",   s_pcnt, ecnt(3));
        check("sat_sticky", s_sticky, 3'b001);
        check("sat_ovr",    s_ovr, 0);

        // Even parity, two stop bits
        e_send(10'h341, 1'b0);
        check("even_ok_dv",   e_dv, 1);
        check("even_ok_data", e_data, 7'h41);
        check("even_ok_perr", e_perr, 0);
        check("even_ok_ferr", e_ferr, 0);
        e_send(10'h241, 1'b1);
        check("even_stop_ferr", e_ferr, 1);
        check("even_stop_perr", e_perr, 0);
        e_send(10'h3C1, 1'b1);
        check("even_par_perr", e_perr, 1);
        check("even_par_ferr", e_ferr, 0);
        check("even_sticky",   e_sticky, 3'b011);

        // Asynchronous reset while FULL with errors
        a_send(9'h0C1, 1'b1, 1'b0);
        check("pre_rst_ferr", a_ferr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dv",     a_dv, 0);
        check("arst_ferr",   a_ferr, 0);
        check("arst_data",   a_data, 0);
        check("arst_sticky", a_sticky, 0);
        check("arst_fcnt",   a_fcnt, 0);
        check("arst_sat",    s_pcnt, 0);

        // Frame strobed during reset is lost
        a_frame = 9'h1C1; a_fv = 1'b1;
        tick();
        a_fv = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rst_frame_lost", a_dv, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
